multicycle_control_fsm: RTL and testbench

// - Multi-cycle sequencer for the MIPS datapath: steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
// - Shares one memory port between instruction fetch and load/store, with a variable-latency MemReq/MemReady handshake.
// - Sits between the IR/register-file/ALU datapath and the unified memory. Replaces single-cycle control decode.

---
 rtl/multicycle_control_fsm_if.sv | 43 ++++
 rtl/multicycle_control_fsm.sv | 260 ++++++++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multi-cycle sequencer and the MIPS datapath/memory.
// master = sequencer side, slave = datapath side.
interface multicycle_control_fsm_if;
  logic [5:0] OPCode;
  logic [5:0] Function;
  logic [4:0] TargetReg;
  logic       Eq;
  logic       RsZero;
  logic       RsNeg;
  logic       MemReady;
  logic       PCWrite;
  logic       IRWrite;
  logic       IorD;
  logic       MemReq;
  logic       MemWrite;
  logic       RegWrite;
  logic [1:0] RegDst;
  logic [1:0] MemToReg;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [5:0] ALUOp;
  logic [1:0] PCSource;
  logic       Illegal;
  logic [2:0] State;

  modport master (
    input  OPCode, Function, TargetReg,
    input  Eq, RsZero, RsNeg, MemReady,
    output PCWrite, IRWrite, IorD, MemReq,
    output MemWrite, RegWrite, RegDst,
    output MemToReg, ALUSrcA, ALUSrcB,
    output ALUOp, PCSource, Illegal, State
  );

  modport slave (
    output OPCode, Function, TargetReg,
    output Eq, RsZero, RsNeg, MemReady,
    input  PCWrite, IRWrite, IorD, MemReq,
    input  MemWrite, RegWrite, RegDst,
    input  MemToReg, ALUSrcA, ALUSrcB,
    input  ALUOp, PCSource, Illegal, State
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS sequencer: FETCH/DECODE/EXEC/MEM/WB over one shared memory port.
// Optional: define PERF_CNT_EN to add CycleCount/InstrCount outputs.
module multicycle_control_fsm #(
  parameter logic [4:0] RA_REG = 5'd31
) (
  input  logic Clk,
  input  logic Rst_n,
  multicycle_control_fsm_if.master bus
`ifdef PERF_CNT_EN
  ,
  output logic [31:0] CycleCount,
  output logic [31:0] InstrCount
`endif
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_e;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_SLTI    = 6'h0a;
  localparam logic [5:0] OP_ANDI    = 6'h0c;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_XORI    = 6'h0e;
  localparam logic [5:0] OP_MUL     = 6'h1c;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2b;
  localparam logic [5:0] F_JR       = 6'h08;
  localparam logic [5:0] F_MUL      = 6'h02;
  localparam logic [5:0] ALU_ADD    = 6'h23;

  // r0 cannot serve as the link register
  if (RA_REG == 5'd0) begin : g_ra_check
    $error("RA_REG must be non-zero");
  end

  state_e state;
  state_e nxt;

  logic funct_ok;
  logic is_jr;
  logic is_rt;
  logic is_j;
  logic is_jal;
  logic is_br;
  logic is_ld;
  logic is_st;
  logic is_ialu;
  logic legal;
  logic taken;

  wire [5:0] op = bus.OPCode;
  wire [5:0] fn = bus.Function;

  // SPECIAL funct codes handled as plain R-type ALU ops (JR decoded apart)
  always_comb begin
    funct_ok = 1'b0;
    case (fn)
      6'h00, 6'h02, 6'h03,
      6'h04, 6'h06, 6'h07,
      6'h20, 6'h21, 6'h22,
      6'h23, 6'h24, 6'h25,
      6'h26, 6'h27, 6'h2a,
      6'h2b:   funct_ok = 1'b1;
      default: funct_ok = 1'b0;
    endcase
  end

  assign is_jr = (op == OP_SPECIAL)
              && (fn == F_JR);
  assign is_rt = ((op == OP_SPECIAL) && funct_ok)
              || ((op == OP_MUL) && (fn == F_MUL));
  assign is_j   = (op == OP_J);
  assign is_jal = (op == OP_JAL);
  assign is_br  = (op == OP_BEQ)
               || (op == OP_BNE)
               || (op == OP_BLEZ)
               || (op == OP_BGTZ)
               || ((op == OP_REGIMM)
                   && (bus.TargetReg[4:1] == 4'd0));
  assign is_ld  = (op == OP_LW)
               || (op == OP_LH)
               || (op == OP_LB);
  assign is_st  = (op == OP_SW)
               || (op == OP_SH)
               || (op == OP_SB);
  assign is_ialu = (op == OP_ADDI)
                || (op == OP_SLTI)
                || (op == OP_ANDI)
                || (op == OP_ORI)
                || (op == OP_XORI);
  assign legal = is_jr | is_rt | is_j
               | is_jal | is_br | is_ld
               | is_st | is_ialu;

  // branch condition from the datapath's rs/rt compare flags
  always_comb begin
    taken = 1'b0;
    case (op)
      OP_BEQ:    taken = bus.Eq;
      OP_BNE:    taken = !bus.Eq;
      OP_BLEZ:   taken = bus.RsNeg | bus.RsZero;
      OP_BGTZ:   taken = !bus.RsNeg & !bus.RsZero;
      OP_REGIMM: taken = bus.TargetReg[0]
                       ? !bus.RsNeg
                       : bus.RsNeg;
      default:   taken = 1'b0;
    endcase
  end

  // state register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= FETCH;
    else        state <= nxt;
  end

  // next-state selection
  always_comb begin
    nxt = state;
    unique case (state)
      FETCH:
        if (bus.MemReady) nxt = DECODE;
      DECODE:
        if (is_j || is_jr || is_jal || !legal)
          nxt = FETCH;
        else
          nxt = EXEC;
      EXEC:
        if (is_ld || is_st) nxt = MEM;
        else if (is_br)     nxt = FETCH;
        else                nxt = WB;
      MEM:
        if (bus.MemReady)
          nxt = is_ld ? WB : FETCH;
      WB:
        nxt = FETCH;
      default:
        nxt = FETCH;
    endcase
  end

  // control outputs; everything held low while in reset
  always_comb begin
    bus.PCWrite  = 1'b0;
    bus.IRWrite  = 1'b0;
    bus.IorD     = 1'b0;
    bus.MemReq   = 1'b0;
    bus.MemWrite = 1'b0;
    bus.RegWrite = 1'b0;
    bus.RegDst   = 2'd0;
    bus.MemToReg = 2'd0;
    bus.ALUSrcA  = 1'b0;
    bus.ALUSrcB  = 2'd0;
    bus.ALUOp    = 6'd0;
    bus.PCSource = 2'd0;
    bus.Illegal  = 1'b0;
    bus.State    = 3'd0;
    if (Rst_n) begin
      bus.State = state;
      unique case (state)
        FETCH: begin
          bus.MemReq  = 1'b1;
          bus.ALUSrcB = 2'd1;
          bus.IRWrite = bus.MemReady;
          bus.PCWrite = bus.MemReady;
        end
        DECODE: begin
          bus.ALUSrcB = 2'd3;
          unique case (1'b1)
            is_j: begin
              bus.PCWrite  = 1'b1;
              bus.PCSource = 2'd2;
            end
            is_jr: begin
              bus.PCWrite  = 1'b1;
              bus.PCSource = 2'd3;
            end
            is_jal: begin
              bus.PCWrite  = 1'b1;
              bus.PCSource = 2'd2;
              bus.RegWrite = 1'b1;
              bus.RegDst   = 2'd2;
              bus.MemToReg = 2'd2;
            end
            !legal:
              bus.Illegal = 1'b1;
            default: ;
          endcase
        end
        EXEC: begin
          bus.ALUSrcA = 1'b1;
          unique case (1'b1)
            is_rt: begin
              bus.ALUSrcB = 2'd0;
              bus.ALUOp   = op;
            end
            is_ialu: begin
              bus.ALUSrcB = 2'd2;
              bus.ALUOp   = op;
            end
            (is_ld || is_st): begin
              bus.ALUSrcB = 2'd2;
              bus.ALUOp   = ALU_ADD;
            end
            is_br: begin
              bus.ALUSrcB  = 2'd0;
              bus.PCSource = 2'd1;
              bus.PCWrite  = taken;
            end
            default: ;
          endcase
        end
        MEM: begin
          bus.MemReq   = 1'b1;
          bus.IorD     = 1'b1;
          bus.MemWrite = is_st;
        end
        WB: begin
          bus.RegWrite = 1'b1;
          bus.RegDst   = is_rt ? 2'd0 : 2'd1;
          bus.MemToReg = is_ld ? 2'd0 : 2'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef PERF_CNT_EN
  // free-running cycle counter
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) CycleCount <= 32'd0;
    else        CycleCount <= CycleCount + 32'd1;
  end

  // retire counter: every return to FETCH
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)
      InstrCount <= 32'd0;
    else if (state != FETCH && nxt == FETCH)
      InstrCount <= InstrCount + 32'd1;
  end
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: directed cases plus random instruction stream
// checked cycle by cycle against a per-instruction-class step model.
module tb_multicycle_control_fsm;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  multicycle_control_fsm_if bus ();

`ifdef PERF_CNT_EN
  logic [31:0] cyc_cnt;
  logic [31:0] ins_cnt;
  int unsigned exp_cyc = 0;
  int unsigned exp_ins = 0;
`endif

  multicycle_control_fsm dut (
    .Clk   (clk),
    .Rst_n (rst_n),
    .bus   (bus.master)
`ifdef PERF_CNT_EN
    ,
    .CycleCount (cyc_cnt),
    .InstrCount (ins_cnt)
`endif
  );

  typedef struct packed {
    logic [2:0] st;
    logic       pcw;
    logic       irw;
    logic       iord;
    logic       mreq;
    logic       mwr;
    logic       rw;
    logic [1:0] rdst;
    logic [1:0] m2r;
    logic       asa;
    logic [1:0] asb;
    logic [5:0] aop;
    logic [1:0] pcs;
    logic       ill;
  } outv_t;

  typedef enum {
    C_J, C_JR, C_JAL, C_ILL,
    C_BR, C_RT, C_IT, C_LD, C_ST
  } cls_e;

  outv_t dut_v;
  assign dut_v = '{
    st:   bus.State,
    pcw:  bus.PCWrite,
    irw:  bus.IRWrite,
    iord: bus.IorD,
    mreq: bus.MemReq,
    mwr:  bus.MemWrite,
    rw:   bus.RegWrite,
    rdst: bus.RegDst,
    m2r:  bus.MemToReg,
    asa:  bus.ALUSrcA,
    asb:  bus.ALUSrcB,
    aop:  bus.ALUOp,
    pcs:  bus.PCSource,
    ill:  bus.Illegal
  };

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h",
               tag, got, exp);
    end
  endtask

  // R-type funct codes the core implements (JR separate)
  logic [5:0] rt_functs [16] = '{
    6'h00, 6'h02, 6'h03, 6'h04,
    6'h06, 6'h07, 6'h20, 6'h21,
    6'h22, 6'h23, 6'h24, 6'h25,
    6'h26, 6'h27, 6'h2a, 6'h2b
  };

  logic [5:0] legal_ops [22] = '{
    6'h00, 6'h00, 6'h00, 6'h1c,
    6'h02, 6'h03, 6'h04, 6'h05,
    6'h06, 6'h07, 6'h01, 6'h08,
    6'h0a, 6'h0c, 6'h0d, 6'h0e,
    6'h23, 6'h21, 6'h20, 6'h2b,
    6'h29, 6'h28
  };

  function automatic cls_e classify(
    logic [5:0] op, logic [5:0] fn, logic [4:0] rt);
    bit fok = 0;
    foreach (rt_functs[i])
      if (rt_functs[i] == fn) fok = 1;
    case (op)
      6'h00: begin
        if (fn == 6'h08) return C_JR;
        return fok ? C_RT : C_ILL;
      end
      6'h1c: return (fn == 6'h02) ? C_RT : C_ILL;
      6'h02: return C_J;
      6'h03: return C_JAL;
      6'h04, 6'h05, 6'h06, 6'h07: return C_BR;
      6'h01: return (rt < 2) ? C_BR : C_ILL;
      6'h08, 6'h0a, 6'h0c, 6'h0d, 6'h0e: return C_IT;
      6'h23, 6'h21, 6'h20: return C_LD;
      6'h2b, 6'h29, 6'h28: return C_ST;
      default: return C_ILL;
    endcase
  endfunction

  function automatic bit br_taken(
    logic [5:0] op, logic [4:0] rt,
    bit eq, bit rz, bit rn);
    case (op)
      6'h04: return eq;
      6'h05: return !eq;
      6'h06: return rn || rz;
      6'h07: return !rn && !rz;
      6'h01: return (rt == 0) ? rn : !rn;
      default: return 0;
    endcase
  endfunction

  // Runs one instruction; entry and exit are at a falling edge.
  // mr per step: 0/1 = forced MemReady, 2 = random (ignored by DUT).
  task automatic run_instr(
    string nm, logic [5:0] op, logic [5:0] fn,
    logic [4:0] rt, bit eq, bit rz, bit rn,
    int fw, int mw, int abort);
    outv_t q[$];
    int    mr[$];
    outv_t o;
    cls_e  c;
    c = classify(op, fn, rt);
    for (int k = 0; k < fw; k++) begin
      o = '0; o.mreq = 1; o.asb = 1;
      q.push_back(o); mr.push_back(0);
    end
    o = '0; o.mreq = 1; o.asb = 1;
    o.irw = 1; o.pcw = 1;
    q.push_back(o); mr.push_back(1);
    o = '0; o.st = 1; o.asb = 3;
    case (c)
      C_J:   begin o.pcw = 1; o.pcs = 2; end
      C_JR:  begin o.pcw = 1; o.pcs = 3; end
      C_JAL: begin
        o.pcw = 1; o.pcs = 2; o.rw = 1;
        o.rdst = 2; o.m2r = 2;
      end
      C_ILL: o.ill = 1;
      default: ;
    endcase
    q.push_back(o); mr.push_back(2);
    if (!(c inside {C_J, C_JR, C_JAL, C_ILL})) begin
      o = '0; o.st = 2; o.asa = 1;
      case (c)
        C_BR: begin
          o.pcs = 1;
          o.pcw = br_taken(op, rt, eq, rz, rn);
        end
        C_RT: o.aop = op;
        C_IT: begin o.asb = 2; o.aop = op; end
        default: begin o.asb = 2; o.aop = 6'h23; end
      endcase
      q.push_back(o); mr.push_back(2);
      if (c == C_LD || c == C_ST) begin
        o = '0; o.st = 3; o.mreq = 1; o.iord = 1;
        o.mwr = (c == C_ST);
        for (int k = 0; k < mw; k++) begin
          q.push_back(o); mr.push_back(0);
        end
        q.push_back(o); mr.push_back(1);
      end
      if (c inside {C_RT, C_IT, C_LD}) begin
        o = '0; o.st = 4; o.rw = 1;
        o.rdst = (c == C_RT) ? 2'd0 : 2'd1;
        o.m2r = (c == C_LD) ? 2'd0 : 2'd1;
        q.push_back(o); mr.push_back(2);
      end
    end
    bus.OPCode = op; bus.Function = fn;
    bus.TargetReg = rt; bus.Eq = eq;
    bus.RsZero = rz; bus.RsNeg = rn;
    for (int i = 0; i < q.size(); i++) begin
      bus.MemReady = (mr[i] == 2)
                   ? 1'($urandom_range(0, 1))
                   : 1'(mr[i]);
      #1;
      chk($sformatf("%s_c%0d op=%0h fn=%0h rt=%0h",
                    nm, i, op, fn, rt),
          32'(dut_v), 32'(q[i]));
`ifdef PERF_CNT_EN
      if (i == 0) begin
        chk({nm, "_cyc"}, cyc_cnt, exp_cyc);
        chk({nm, "_ins"}, ins_cnt, exp_ins);
      end
`endif
      if (i == abort) begin
        #3 rst_n = 1'b0;
        #1 chk({nm, "_rst_async"}, 32'(dut_v), 32'd0);
        @(negedge clk);
        chk({nm, "_rst_hold"}, 32'(dut_v), 32'd0);
        rst_n = 1'b1;
        bus.MemReady = 1'b0;
`ifdef PERF_CNT_EN
        exp_cyc = 0; exp_ins = 0;
`endif
        return;
      end
      @(negedge clk);
`ifdef PERF_CNT_EN
      exp_cyc++;
`endif
    end
`ifdef PERF_CNT_EN
    exp_ins++;
`endif
  endtask

  initial begin
    bus.OPCode = '0; bus.Function = '0;
    bus.TargetReg = '0; bus.Eq = 0;
    bus.RsZero = 0; bus.RsNeg = 0;
    bus.MemReady = 1'b1;
    repeat (3) @(negedge clk);
    #1 chk("reset_out", 32'(dut_v), 32'd0);
`ifdef PERF_CNT_EN
    chk("reset_cyc", cyc_cnt, 32'd0);
    chk("reset_ins", ins_cnt, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    run_instr("sw_abort", 6'h2b, 0, 0, 0, 0, 0, 0, 3, 3);
    run_instr("addi", 6'h08, 0, 0, 0, 0, 0, 0, 0, -1);
    run_instr("lw_wait", 6'h23, 0, 0, 0, 0, 0, 0, 3, -1);
    run_instr("beq_t", 6'h04, 0, 0, 1, 0, 0, 0, 0, -1);
    run_instr("bne_nt", 6'h05, 0, 0, 1, 0, 0, 0, 0, -1);
    run_instr("blez_z", 6'h06, 0, 0, 0, 1, 0, 0, 0, -1);
    run_instr("regimm_ill", 6'h01, 0, 5'd2, 0, 0, 0, 0, 0, -1);
    run_instr("jal", 6'h03, 0, 0, 0, 0, 0, 0, 0, -1);
    run_instr("jr", 6'h00, 6'h08, 0, 0, 0, 0, 0, 0, -1);
    run_instr("j_fwait", 6'h02, 0, 0, 0, 0, 0, 2, 0, -1);
    run_instr("sw", 6'h2b, 0, 0, 0, 0, 0, 1, 1, -1);
    run_instr("mul", 6'h1c, 6'h02, 0, 0, 0, 0, 0, 0, -1);
    run_instr("add", 6'h00, 6'h20, 0, 0, 0, 0, 0, 0, -1);
    run_instr("bltz", 6'h01, 0, 5'd0, 0, 0, 1, 0, 0, -1);
    run_instr("bgez", 6'h01, 0, 5'd1, 0, 0, 1, 0, 0, -1);

    for (int n = 0; n < 400; n++) begin
      logic [5:0] op;
      logic [5:0] fn;
      logic [4:0] rt;
      if ($urandom_range(0, 9) < 3) begin
        op = 6'($urandom);
        fn = 6'($urandom);
        rt = 5'($urandom);
      end else begin
        op = legal_ops[$urandom_range(0, 21)];
        fn = 6'($urandom);
        rt = 5'($urandom);
        if (op == 6'h00)
          fn = ($urandom_range(0, 7) == 0)
             ? 6'h08
             : rt_functs[$urandom_range(0, 15)];
        if (op == 6'h1c && $urandom_range(0, 3) != 0)
          fn = 6'h02;
        if (op == 6'h01)
          rt = 5'($urandom_range(0, 2));
      end
      run_instr("rnd", op, fn, rt,
                1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)),
                $urandom_range(0, 3),
                $urandom_range(0, 3), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
